// File: rtl/fastram_sdram_bridge_if.sv
// SDRAM-side word request channel of the fast-RAM bridge: level request, one-cycle ack.
// The bridge drives the request side (master); the SDRAM controller answers (slave).
interface fastram_sdram_bridge_if;
    logic        sd_req;
    logic        sd_we;
    logic [21:0] sd_addr;
    logic [1:0]  sd_be;
    logic [15:0] sd_wdata;
    logic [15:0] sd_rdata;
    logic        sd_ack;

    modport master (
        output sd_req, sd_we, sd_addr, sd_be, sd_wdata,
        input  sd_rdata, sd_ack
    );

    modport slave (
        input  sd_req, sd_we, sd_addr, sd_be, sd_wdata,
        output sd_rdata, sd_ack
    );
endinterface

// File: rtl/fastram_sdram_bridge.sv
// Byte-wide fast-RAM port to 16-bit SDRAM word requests, with a one-word read line
// and a one-entry posted write; the core is stalled only on read misses and conflicts.
module fastram_sdram_bridge #(
    parameter int unsigned TIMEOUT     = 256,
    parameter int unsigned LINE_ENABLE = 1
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic                          cpu_strobe,
    input  logic                          cpu_ce,
    input  logic                          cpu_we,
    input  logic [22:0]                   cpu_addr,
    input  logic [7:0]                    cpu_din,
    output logic [7:0]                    cpu_dout,
    output logic                          cpu_wait,
    input  logic                          flush,
    fastram_sdram_bridge_if.master        sd,
    output logic                          err
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_DONE} state_t;

    state_t      state_q, state_d;
    logic        stall_q, stall_d;
    logic        line_valid_q, line_valid_d;
    logic [21:0] line_tag_q, line_tag_d;
    logic [15:0] line_data_q, line_data_d;
    logic [7:0]  cpu_dout_q, cpu_dout_d;
    logic        err_q, err_d;
    logic        sd_req_q, sd_req_d;
    logic        sd_we_q, sd_we_d;
    logic [21:0] sd_addr_q, sd_addr_d;
    logic [1:0]  sd_be_q, sd_be_d;
    logic [15:0] sd_wdata_q, sd_wdata_d;
    logic        rd_hi_q, rd_hi_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic       accept, hit, tag_match, ack, tmo;
    logic [7:0] hit_byte, rd_byte;

    always_comb begin
        accept    = cpu_strobe & cpu_ce;
        tag_match = line_valid_q && (line_tag_q == cpu_addr[22:1]);
        hit       = (LINE_ENABLE != 0) && tag_match;
        ack       = sd.sd_ack & sd_req_q;
        tmo       = sd_req_q && !sd.sd_ack && (tmo_cnt_q == TMO_LAST);
        hit_byte  = cpu_addr[0] ? line_data_q[15:8] : line_data_q[7:0];
        rd_byte   = rd_hi_q ? sd.sd_rdata[15:8] : sd.sd_rdata[7:0];

        state_d      = state_q;
        line_valid_d = line_valid_q;
        line_tag_d   = line_tag_q;
        line_data_d  = line_data_q;
        cpu_dout_d   = cpu_dout_q;
        err_d        = err_q;
        sd_req_d     = sd_req_q;
        sd_we_d      = sd_we_q;
        sd_addr_d    = sd_addr_q;
        sd_be_d      = sd_be_q;
        sd_wdata_d   = sd_wdata_q;
        rd_hi_d      = rd_hi_q;
        cpu_wait     = 1'b0;

        // Flush is applied first so a coincident fill below still leaves the line valid.
        if (flush) line_valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cpu_we) begin
                        state_d    = WR_REQ;
                        sd_req_d   = 1'b1;
                        sd_we_d    = 1'b1;
                        sd_addr_d  = cpu_addr[22:1];
                        sd_be_d    = cpu_addr[0] ? 2'b10 : 2'b01;
                        sd_wdata_d = {cpu_din, cpu_din};
                        if (tag_match) begin
                            if (cpu_addr[0]) line_data_d[15:8] = cpu_din;
                            else             line_data_d[7:0]  = cpu_din;
                        end
                    end else if (hit) begin
                        cpu_dout_d = hit_byte;
                    end else begin
                        cpu_wait  = 1'b1;
                        state_d   = RD_REQ;
                        sd_req_d  = 1'b1;
                        sd_we_d   = 1'b0;
                        sd_addr_d = cpu_addr[22:1];
                        sd_be_d   = 2'b11;
                        rd_hi_d   = cpu_addr[0];
                    end
                end
            end
            WR_REQ, RD_REQ: begin
                cpu_wait = (state_q == RD_REQ) | stall_q | accept;
                if (ack) begin
                    sd_req_d = 1'b0;
                    if (state_q == RD_REQ) begin
                        line_valid_d = 1'b1;
                        line_tag_d   = sd_addr_q;
                        line_data_d  = sd.sd_rdata;
                        cpu_dout_d   = rd_byte;
                        state_d      = RD_DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (tmo) begin
                    sd_req_d     = 1'b0;
                    err_d        = 1'b1;
                    line_valid_d = 1'b0;
                    if (state_q == RD_REQ) cpu_dout_d = 8'hFF;
                    state_d = IDLE;
                end
            end
            RD_DONE: begin
                cpu_wait = stall_q | accept;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A strobe refused outside IDLE keeps the core stalled until the bridge is idle again.
        stall_d   = (state_d != IDLE) && (stall_q || (state_q != IDLE && accept));
        tmo_cnt_d = (sd_req_q && sd_req_d) ? tmo_cnt_q + CW'(1) : '0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            stall_q      <= 1'b0;
            line_valid_q <= 1'b0;
            line_tag_q   <= '0;
            line_data_q  <= '0;
            cpu_dout_q   <= 8'hFF;
            err_q        <= 1'b0;
            sd_req_q     <= 1'b0;
            sd_we_q      <= 1'b0;
            sd_addr_q    <= '0;
            sd_be_q      <= '0;
            sd_wdata_q   <= '0;
            rd_hi_q      <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            stall_q      <= stall_d;
            line_valid_q <= line_valid_d;
            line_tag_q   <= line_tag_d;
            line_data_q  <= line_data_d;
            cpu_dout_q   <= cpu_dout_d;
            err_q        <= err_d;
            sd_req_q     <= sd_req_d;
            sd_we_q      <= sd_we_d;
            sd_addr_q    <= sd_addr_d;
            sd_be_q      <= sd_be_d;
            sd_wdata_q   <= sd_wdata_d;
            rd_hi_q      <= rd_hi_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign cpu_dout    = cpu_dout_q;
    assign err         = err_q;
    assign sd.sd_req   = sd_req_q;
    assign sd.sd_we    = sd_we_q;
    assign sd.sd_addr  = sd_addr_q;
    assign sd.sd_be    = sd_be_q;
    assign sd.sd_wdata = sd_wdata_q;

endmodule

// File: tb/tb_fastram_sdram_bridge.sv
// Directed bench for fastram_sdram_bridge: writes, read hit/miss, merge, stall on a
// pending write, timeout, flush and asynchronous reset mid-request.
module tb_fastram_sdram_bridge;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_strobe = 1'b0;
    logic        cpu_ce = 1'b0;
    logic        cpu_we = 1'b0;
    logic [22:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_wait;
    logic        flush = 1'b0;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    fastram_sdram_bridge_if sd_if ();

    fastram_sdram_bridge #(.TIMEOUT(16), .LINE_ENABLE(1)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .cpu_strobe (cpu_strobe),
        .cpu_ce     (cpu_ce),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_wait   (cpu_wait),
        .flush      (flush),
        .sd         (sd_if),
        .err        (err)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One strobe cycle; cpu_wait is sampled combinationally inside the strobe cycle.
    task automatic access(input logic we, input logic [22:0] a, input logic [7:0] d,
                          input logic exp_wait, input string tag);
        cpu_strobe = 1'b1;
        cpu_ce     = 1'b1;
        cpu_we     = we;
        cpu_addr   = a;
        cpu_din    = d;
        #1;
        chk(tag, 32'(cpu_wait), 32'(exp_wait));
        tick();
        cpu_strobe = 1'b0;
        cpu_ce     = 1'b0;
        cpu_we     = 1'b0;
    endtask

    task automatic serve(input int dly, input logic [15:0] rd);
        int w = 0;
        while (!sd_if.sd_req && w < 50) begin
            tick();
            w++;
        end
        chk("serve_req", 32'(sd_if.sd_req), 32'd1);
        repeat (dly) tick();
        sd_if.sd_rdata = rd;
        sd_if.sd_ack   = 1'b1;
        tick();
        sd_if.sd_ack   = 1'b0;
        tick();
    endtask

    initial begin
        int held;
        int n;
        sd_if.sd_ack   = 1'b0;
        sd_if.sd_rdata = '0;

        // Reset state
        tick();
        chk("rst_req",  32'(sd_if.sd_req), 32'd0);
        chk("rst_wait", 32'(cpu_wait),     32'd0);
        chk("rst_dout", 32'(cpu_dout),     32'hFF);
        chk("rst_err",  32'(err),          32'd0);
        chk("rst_addr", 32'(sd_if.sd_addr), 32'd0);
        reset_n = 1'b1;
        tick();

        // Stray ack while idle is ignored
        sd_if.sd_ack = 1'b1;
        tick();
        sd_if.sd_ack = 1'b0;
        tick();
        chk("stray_ack_req",  32'(sd_if.sd_req), 32'd0);
        chk("stray_ack_dout", 32'(cpu_dout),     32'hFF);

        // 1: posted write
        access(1'b1, 23'h012345, 8'hA5, 1'b0, "wr1_wait");
        chk("wr1_req",   32'(sd_if.sd_req),   32'd1);
        chk("wr1_we",    32'(sd_if.sd_we),    32'd1);
        chk("wr1_addr",  32'(sd_if.sd_addr),  32'h0091A2);
        chk("wr1_be",    32'(sd_if.sd_be),    32'h2);
        chk("wr1_wdata", 32'(sd_if.sd_wdata), 32'hA5A5);
        repeat (3) tick();
        chk("wr1_hold_req",  32'(sd_if.sd_req),  32'd1);
        chk("wr1_hold_addr", 32'(sd_if.sd_addr), 32'h0091A2);
        sd_if.sd_ack = 1'b1;
        tick();
        sd_if.sd_ack = 1'b0;
        chk("wr1_req_drop", 32'(sd_if.sd_req), 32'd0);
        tick();

        // 2: read miss then hit on the other byte
        access(1'b0, 23'h000100, 8'h00, 1'b1, "rd2_miss_wait");
        chk("rd2_req",  32'(sd_if.sd_req),  32'd1);
        chk("rd2_we",   32'(sd_if.sd_we),   32'd0);
        chk("rd2_addr", 32'(sd_if.sd_addr), 32'h000080);
        sd_if.sd_rdata = 16'h3412;
        sd_if.sd_ack   = 1'b1;
        #1;
        chk("rd2_wait_ackcyc", 32'(cpu_wait), 32'd1);
        tick();
        sd_if.sd_ack = 1'b0;
        #1;
        chk("rd2_wait_after", 32'(cpu_wait), 32'd0);
        chk("rd2_dout",       32'(cpu_dout), 32'h12);
        tick();
        access(1'b0, 23'h000101, 8'h00, 1'b0, "rd2_hit_wait");
        chk("rd2_hit_dout", 32'(cpu_dout),     32'h34);
        chk("rd2_hit_noreq", 32'(sd_if.sd_req), 32'd0);

        // 3: write merges into the line
        access(1'b1, 23'h000101, 8'h77, 1'b0, "wr3_wait");
        chk("wr3_be", 32'(sd_if.sd_be), 32'h2);
        serve(0, 16'h0000);
        access(1'b0, 23'h000101, 8'h00, 1'b0, "rd3_hit_wait");
        chk("rd3_dout",  32'(cpu_dout),     32'h77);
        chk("rd3_noreq", 32'(sd_if.sd_req), 32'd0);

        // 4: read strobe while a write is pending
        access(1'b1, 23'h000200, 8'h55, 1'b0, "wr4_wait");
        chk("wr4_be",   32'(sd_if.sd_be),   32'h1);
        chk("wr4_addr", 32'(sd_if.sd_addr), 32'h000100);
        access(1'b0, 23'h000100, 8'h00, 1'b1, "rd4_blocked_wait");
        held = 0;
        for (int i = 0; i < 10; i++) begin
            if (cpu_wait) held++;
            tick();
        end
        chk("rd4_held_cycles", 32'(held), 32'd10);
        chk("rd4_still_write", 32'(sd_if.sd_we), 32'd1);
        sd_if.sd_ack = 1'b1;
        #1;
        chk("rd4_wait_ackcyc", 32'(cpu_wait), 32'd1);
        tick();
        sd_if.sd_ack = 1'b0;
        #1;
        chk("rd4_wait_released", 32'(cpu_wait), 32'd0);
        access(1'b0, 23'h000100, 8'h00, 1'b0, "rd4_retry_wait");
        chk("rd4_dout",  32'(cpu_dout),     32'h12);
        chk("rd4_noreq", 32'(sd_if.sd_req), 32'd0);

        // 5: timeout on a read
        access(1'b0, 23'h000300, 8'h00, 1'b1, "rd5_miss_wait");
        n = 0;
        for (int i = 0; i < 40 && sd_if.sd_req; i++) begin
            n++;
            tick();
        end
        chk("tmo_req_cycles", 32'(n),        32'd16);
        chk("tmo_err",        32'(err),      32'd1);
        chk("tmo_dout",       32'(cpu_dout), 32'hFF);
        chk("tmo_wait",       32'(cpu_wait), 32'd0);
        access(1'b0, 23'h000100, 8'h00, 1'b1, "tmo_line_inval_wait");
        serve(2, 16'hBEEF);
        chk("tmo_next_dout", 32'(cpu_dout), 32'hEF);
        chk("tmo_err_sticky", 32'(err),     32'd1);

        // flush invalidates the line
        access(1'b0, 23'h000101, 8'h00, 1'b0, "fl_hit_wait");
        chk("fl_hit_dout", 32'(cpu_dout), 32'hBE);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        access(1'b0, 23'h000101, 8'h00, 1'b1, "fl_miss_wait");
        serve(1, 16'hCAFE);
        chk("fl_fill_dout", 32'(cpu_dout), 32'hCA);

        // 6: asynchronous reset during a read request
        access(1'b0, 23'h000200, 8'h00, 1'b1, "rst6_miss_wait");
        tick();
        chk("rst6_req_before", 32'(sd_if.sd_req), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst6_req",  32'(sd_if.sd_req), 32'd0);
        chk("rst6_wait", 32'(cpu_wait),     32'd0);
        chk("rst6_dout", 32'(cpu_dout),     32'hFF);
        chk("rst6_err",  32'(err),          32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        access(1'b0, 23'h000101, 8'h00, 1'b1, "rst6_first_miss");
        serve(0, 16'h1234);
        chk("rst6_dout_after", 32'(cpu_dout), 32'h12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
